// File: rtl/alu_reservation_station_if.sv
// Dispatch, result-broadcast and issue bundle of the ALU reservation station.
// slave = reservation station side, master = surrounding pipeline side.
interface alu_reservation_station_if #(
  parameter int ROB_IDX_W = 4,
  parameter int OP_W      = 6,
  parameter int XLEN      = 32
);
  logic                 dec_valid;
  logic [OP_W-1:0]      dec_op;
  logic [ROB_IDX_W-1:0] dec_rob_index;
  logic [XLEN-1:0]      dec_PC;
  logic [XLEN-1:0]      dec_imm;
  logic [XLEN-1:0]      dec_rs1_val;
  logic [XLEN-1:0]      dec_rs2_val;
  logic                 dec_rs1_busy;
  logic                 dec_rs2_busy;
  logic [ROB_IDX_W-1:0] dec_rs1_tag;
  logic [ROB_IDX_W-1:0] dec_rs2_tag;
  logic                 alu_ready;
  logic [XLEN-1:0]      alu_result;
  logic [ROB_IDX_W-1:0] alu_rob_index;
  logic                 lsb_ready;
  logic [XLEN-1:0]      lsb_result;
  logic [ROB_IDX_W-1:0] lsb_rob_index;
  logic                 rs_full;
  logic                 rs_to_alu_ready;
  logic [OP_W-1:0]      rs_to_alu_op;
  logic [XLEN-1:0]      rs_to_alu_rs1;
  logic [XLEN-1:0]      rs_to_alu_rs2;
  logic [ROB_IDX_W-1:0] rs_to_alu_rob_index;
  logic [XLEN-1:0]      rs_to_alu_PC;
  logic [XLEN-1:0]      rs_to_alu_imm;

  modport slave (
    input  dec_valid, dec_op, dec_rob_index, dec_PC, dec_imm,
           dec_rs1_val, dec_rs2_val, dec_rs1_busy, dec_rs2_busy, dec_rs1_tag, dec_rs2_tag,
           alu_ready, alu_result, alu_rob_index, lsb_ready, lsb_result, lsb_rob_index,
    output rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
           rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm
  );

  modport master (
    output dec_valid, dec_op, dec_rob_index, dec_PC, dec_imm,
           dec_rs1_val, dec_rs2_val, dec_rs1_busy, dec_rs2_busy, dec_rs1_tag, dec_rs2_tag,
           alu_ready, alu_result, alu_rob_index, lsb_ready, lsb_result, lsb_rob_index,
    input  rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
           rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Out-of-order issue buffer in front of the ALU: tag wakeup from ALU/LSB broadcasts, one issue per cycle.
// Optional RS_OLDEST_FIRST_EN: per-entry 8-bit age, issue picks the oldest ready entry.
module alu_reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_IDX_W = 4,
  parameter int OP_W      = 6,
  parameter int XLEN      = 32
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic clr_in,
  alu_reservation_station_if.slave bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = $clog2(RS_SIZE) + 1;

  logic [RS_SIZE-1:0]   valid_r;
  logic [RS_SIZE-1:0]   busy1_r;
  logic [RS_SIZE-1:0]   busy2_r;
  logic [OP_W-1:0]      op_r   [RS_SIZE];
  logic [ROB_IDX_W-1:0] rob_r  [RS_SIZE];
  logic [XLEN-1:0]      pc_r   [RS_SIZE];
  logic [XLEN-1:0]      imm_r  [RS_SIZE];
  logic [ROB_IDX_W-1:0] tag1_r [RS_SIZE];
  logic [ROB_IDX_W-1:0] tag2_r [RS_SIZE];
  logic [XLEN-1:0]      val1_r [RS_SIZE];
  logic [XLEN-1:0]      val2_r [RS_SIZE];
`ifdef RS_OLDEST_FIRST_EN
  logic [7:0]           age_r  [RS_SIZE];
  logic [7:0]           best_age_s;
`endif
  logic [CNT_W-1:0]     count_r;

  logic                 full_s;
  logic                 dispatch_s;
  logic [RS_SIZE-1:0]   cand_s;
  logic                 issue_found_s;
  logic [IDX_W-1:0]     issue_idx_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic [XLEN:0]        byp1_s;
  logic [XLEN:0]        byp2_s;

  // Resolves a pending operand against both broadcasts; returns {busy, value}, ALU taking priority.
  function automatic logic [XLEN:0] resolve(
    input logic                 busy,
    input logic [ROB_IDX_W-1:0] tag,
    input logic [XLEN-1:0]      val,
    input logic                 a_rdy,
    input logic [ROB_IDX_W-1:0] a_tag,
    input logic [XLEN-1:0]      a_val,
    input logic                 l_rdy,
    input logic [ROB_IDX_W-1:0] l_tag,
    input logic [XLEN-1:0]      l_val
  );
    if (busy && a_rdy && (a_tag == tag)) begin
      return {1'b0, a_val};
    end else if (busy && l_rdy && (l_tag == tag)) begin
      return {1'b0, l_val};
    end else begin
      return {busy, val};
    end
  endfunction

  assign full_s      = (count_r == CNT_W'(RS_SIZE));
  assign dispatch_s  = bus.dec_valid & ~full_s;
  assign cand_s      = valid_r & ~busy1_r & ~busy2_r;
  assign bus.rs_full = full_s;

  // Dispatch-time operand bypass from same-cycle broadcasts.
  always_comb begin
    byp1_s = resolve(bus.dec_rs1_busy, bus.dec_rs1_tag, bus.dec_rs1_val,
                     bus.alu_ready, bus.alu_rob_index, bus.alu_result,
                     bus.lsb_ready, bus.lsb_rob_index, bus.lsb_result);
    byp2_s = resolve(bus.dec_rs2_busy, bus.dec_rs2_tag, bus.dec_rs2_val,
                     bus.alu_ready, bus.alu_rob_index, bus.alu_result,
                     bus.lsb_ready, bus.lsb_rob_index, bus.lsb_result);
  end

  // Lowest free slot and issue selection from start-of-cycle state.
  always_comb begin
    free_idx_s    = {IDX_W{1'b0}};
    issue_idx_s   = {IDX_W{1'b0}};
    issue_found_s = |cand_s;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_idx_s = !valid_r[i] ? IDX_W'(i) : free_idx_s;
    end
`ifdef RS_OLDEST_FIRST_EN
    best_age_s = 8'd0;
    for (int i = 0; i < RS_SIZE; i++) begin
      // Strict compare keeps ties on the lowest index.
      if (cand_s[i] && ((!cand_s[issue_idx_s]) || (age_r[i] > best_age_s))) begin
        issue_idx_s = IDX_W'(i);
        best_age_s  = age_r[i];
      end else begin
        best_age_s  = best_age_s;
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      issue_idx_s = cand_s[i] ? IDX_W'(i) : issue_idx_s;
    end
`endif
  end

  // Entry state, occupancy and registered issue port.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_r <= {RS_SIZE{1'b0}};
      busy1_r <= {RS_SIZE{1'b0}};
      busy2_r <= {RS_SIZE{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < RS_SIZE; i++) begin
        op_r[i]   <= {OP_W{1'b0}};
        rob_r[i]  <= {ROB_IDX_W{1'b0}};
        pc_r[i]   <= {XLEN{1'b0}};
        imm_r[i]  <= {XLEN{1'b0}};
        tag1_r[i] <= {ROB_IDX_W{1'b0}};
        tag2_r[i] <= {ROB_IDX_W{1'b0}};
        val1_r[i] <= {XLEN{1'b0}};
        val2_r[i] <= {XLEN{1'b0}};
`ifdef RS_OLDEST_FIRST_EN
        age_r[i]  <= 8'd0;
`endif
      end
      bus.rs_to_alu_ready     <= 1'b0;
      bus.rs_to_alu_op        <= {OP_W{1'b0}};
      bus.rs_to_alu_rs1       <= {XLEN{1'b0}};
      bus.rs_to_alu_rs2       <= {XLEN{1'b0}};
      bus.rs_to_alu_rob_index <= {ROB_IDX_W{1'b0}};
      bus.rs_to_alu_PC        <= {XLEN{1'b0}};
      bus.rs_to_alu_imm       <= {XLEN{1'b0}};
    end else if (rdy_in) begin
      if (clr_in) begin
        valid_r             <= {RS_SIZE{1'b0}};
        count_r             <= {CNT_W{1'b0}};
        bus.rs_to_alu_ready <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          {busy1_r[i], val1_r[i]} <= resolve(busy1_r[i], tag1_r[i], val1_r[i],
                                             bus.alu_ready, bus.alu_rob_index, bus.alu_result,
                                             bus.lsb_ready, bus.lsb_rob_index, bus.lsb_result);
          {busy2_r[i], val2_r[i]} <= resolve(busy2_r[i], tag2_r[i], val2_r[i],
                                             bus.alu_ready, bus.alu_rob_index, bus.alu_result,
                                             bus.lsb_ready, bus.lsb_rob_index, bus.lsb_result);
`ifdef RS_OLDEST_FIRST_EN
          if (valid_r[i] && (age_r[i] != 8'd255)) begin
            age_r[i] <= age_r[i] + 8'd1;
          end
`endif
        end
        bus.rs_to_alu_ready <= issue_found_s;
        if (issue_found_s) begin
          valid_r[issue_idx_s]    <= 1'b0;
          bus.rs_to_alu_op        <= op_r[issue_idx_s];
          bus.rs_to_alu_rs1       <= val1_r[issue_idx_s];
          bus.rs_to_alu_rs2       <= val2_r[issue_idx_s];
          bus.rs_to_alu_rob_index <= rob_r[issue_idx_s];
          bus.rs_to_alu_PC        <= pc_r[issue_idx_s];
          bus.rs_to_alu_imm       <= imm_r[issue_idx_s];
        end
        // The free slot was invalid at cycle start, so it never collides with the issuing slot.
        if (dispatch_s) begin
          valid_r[free_idx_s]                 <= 1'b1;
          op_r[free_idx_s]                    <= bus.dec_op;
          rob_r[free_idx_s]                   <= bus.dec_rob_index;
          pc_r[free_idx_s]                    <= bus.dec_PC;
          imm_r[free_idx_s]                   <= bus.dec_imm;
          tag1_r[free_idx_s]                  <= bus.dec_rs1_tag;
          tag2_r[free_idx_s]                  <= bus.dec_rs2_tag;
          {busy1_r[free_idx_s], val1_r[free_idx_s]} <= byp1_s;
          {busy2_r[free_idx_s], val2_r[free_idx_s]} <= byp2_s;
`ifdef RS_OLDEST_FIRST_EN
          age_r[free_idx_s]                   <= 8'd0;
`endif
        end
        count_r <= count_r + CNT_W'(dispatch_s) - CNT_W'(issue_found_s);
      end
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: issue latency, wakeup, bypass, fill/drain, flush, stall, age order.
module tb_alu_reservation_station;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_reservation_station_if #(.ROB_IDX_W(4), .OP_W(6), .XLEN(32)) bus ();

  alu_reservation_station #(.RS_SIZE(16), .ROB_IDX_W(4), .OP_W(6), .XLEN(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clr_in(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [5:0] op, input logic [3:0] rob,
                     input logic [31:0] r1, input logic b1, input logic [3:0] t1,
                     input logic [31:0] r2, input logic b2, input logic [3:0] t2);
    bus.dec_valid     = v;
    bus.dec_op        = op;
    bus.dec_rob_index = rob;
    bus.dec_PC        = 32'h1000 + {28'd0, rob};
    bus.dec_imm       = 32'h4;
    bus.dec_rs1_val   = r1;
    bus.dec_rs1_busy  = b1;
    bus.dec_rs1_tag   = t1;
    bus.dec_rs2_val   = r2;
    bus.dec_rs2_busy  = b2;
    bus.dec_rs2_tag   = t2;
  endtask

  task automatic idle();
    bus.dec_valid = 1'b0;
    bus.alu_ready = 1'b0;
    bus.lsb_ready = 1'b0;
  endtask

  initial begin
    dec(1'b0, 6'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    bus.alu_ready = 1'b0; bus.alu_result = 32'd0; bus.alu_rob_index = 4'd0;
    bus.lsb_ready = 1'b0; bus.lsb_result = 32'd0; bus.lsb_rob_index = 4'd0;
    step(); step();
    check("rst_ready", {31'd0, bus.rs_to_alu_ready}, 32'd0);
    check("rst_full", {31'd0, bus.rs_full}, 32'd0);
    check("rst_rs1", bus.rs_to_alu_rs1, 32'd0);
    check("rst_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd0);
    rst = 1'b0;
    step();

    // Ready operands: one cycle after dispatch edge.
    dec(1'b1, 6'd1, 4'd3, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0);
    step(); idle();
    check("add_not_yet", {31'd0, bus.rs_to_alu_ready}, 32'd0);
    step();
    check("add_ready", {31'd0, bus.rs_to_alu_ready}, 32'd1);
    check("add_rs1", bus.rs_to_alu_rs1, 32'd5);
    check("add_rs2", bus.rs_to_alu_rs2, 32'd7);
    check("add_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd3);
    check("add_op", {26'd0, bus.rs_to_alu_op}, 32'd1);
    check("add_pc", bus.rs_to_alu_PC, 32'h1003);
    step();
    check("add_done", {31'd0, bus.rs_to_alu_ready}, 32'd0);
    check("add_hold_rs1", bus.rs_to_alu_rs1, 32'd5);

    // ALU broadcast wakeup.
    dec(1'b1, 6'd2, 4'd4, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0);
    step(); idle();
    step();
    check("wake_held", {31'd0, bus.rs_to_alu_ready}, 32'd0);
    bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd2; bus.alu_result = 32'h10;
    step(); idle();
    check("wake_edge", {31'd0, bus.rs_to_alu_ready}, 32'd0);
    step();
    check("wake_ready", {31'd0, bus.rs_to_alu_ready}, 32'd1);
    check("wake_rs1", bus.rs_to_alu_rs1, 32'h10);
    check("wake_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd4);

    // Dispatch-time bypass from LSB.
    dec(1'b1, 6'd3, 4'd5, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6);
    bus.lsb_ready = 1'b1; bus.lsb_rob_index = 4'd6; bus.lsb_result = 32'hABCD;
    step(); idle();
    step();
    check("byp_ready", {31'd0, bus.rs_to_alu_ready}, 32'd1);
    check("byp_rs2", bus.rs_to_alu_rs2, 32'hABCD);
    check("byp_rs1", bus.rs_to_alu_rs1, 32'd3);
    check("byp_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd5);

    // rdy low: outputs hold, dispatch ignored.
    dec(1'b1, 6'd4, 4'd8, 32'd8, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0);
    step(); idle();
    step();
    check("stall_pre", {28'd0, bus.rs_to_alu_rob_index}, 32'd8);
    rdy = 1'b0;
    dec(1'b1, 6'd4, 4'd7, 32'd7, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0);
    step(); step();
    check("stall_hold_rdy", {31'd0, bus.rs_to_alu_ready}, 32'd1);
    check("stall_hold_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd8);
    rdy = 1'b1; idle();
    step();
    check("stall_no_disp", {31'd0, bus.rs_to_alu_ready}, 32'd0);
    step();
    check("stall_no_disp2", {31'd0, bus.rs_to_alu_ready}, 32'd0);

    // Fill all 16 entries waiting on tag 9, then drain in index order.
    for (int i = 0; i < 16; i++) begin
      check("fill_not_full", {31'd0, bus.rs_full}, 32'd0);
      dec(1'b1, 6'd5, i[3:0], 32'd0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0);
      step();
    end
    idle();
    check("fill_full", {31'd0, bus.rs_full}, 32'd1);
    check("fill_no_issue", {31'd0, bus.rs_to_alu_ready}, 32'd0);
    bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd9; bus.alu_result = 32'h99;
    step(); idle();
    check("drain_wake_full", {31'd0, bus.rs_full}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      check("drain_ready", {31'd0, bus.rs_to_alu_ready}, 32'd1);
      check("drain_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'(i));
      check("drain_rs2", bus.rs_to_alu_rs2, 32'(i));
      check("drain_rs1", bus.rs_to_alu_rs1, 32'h99);
      check("drain_full", {31'd0, bus.rs_full}, 32'd0);
    end
    step();
    check("drain_empty", {31'd0, bus.rs_to_alu_ready}, 32'd0);

    // Flush overrides same-cycle dispatch.
    for (int i = 0; i < 4; i++) begin
      dec(1'b1, 6'd6, i[3:0], 32'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0);
      step();
    end
    dec(1'b1, 6'd6, 4'd10, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
    clr = 1'b1;
    step();
    clr = 1'b0; idle();
    check("clr_ready", {31'd0, bus.rs_to_alu_ready}, 32'd0);
    check("clr_full", {31'd0, bus.rs_full}, 32'd0);
    bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd12; bus.alu_result = 32'h5;
    step(); idle();
    check("clr_no_issue1", {31'd0, bus.rs_to_alu_ready}, 32'd0);
    step();
    check("clr_no_issue2", {31'd0, bus.rs_to_alu_ready}, 32'd0);

    // Age ordering: A into entry 1, later B into entry 0, woken together.
    dec(1'b1, 6'd7, 4'd1, 32'd0, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0);
    step();
    dec(1'b1, 6'd7, 4'd2, 32'd0, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0);
    step(); idle();
    bus.alu_ready = 1'b1; bus.alu_rob_index = 4'd5; bus.alu_result = 32'h1;
    step(); idle();
    step();
    check("age_x_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd1);
    dec(1'b1, 6'd7, 4'd3, 32'd0, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0);
    step(); idle();
    step();
    bus.lsb_ready = 1'b1; bus.lsb_rob_index = 4'd7; bus.lsb_result = 32'h77;
    step(); idle();
    step();
    check("age_first_ready", {31'd0, bus.rs_to_alu_ready}, 32'd1);
`ifdef RS_OLDEST_FIRST_EN
    check("age_first_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd2);
`else
    check("age_first_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd3);
`endif
    step();
    check("age_second_ready", {31'd0, bus.rs_to_alu_ready}, 32'd1);
`ifdef RS_OLDEST_FIRST_EN
    check("age_second_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd3);
`else
    check("age_second_rob", {28'd0, bus.rs_to_alu_rob_index}, 32'd2);
`endif
    check("age_second_rs1", bus.rs_to_alu_rs1, 32'h77);
    step();
    check("age_done", {31'd0, bus.rs_to_alu_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
